// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory window.
// One transaction in flight: IDLE -> ACCESS -> RESP for valid requests, IDLE -> RESP for invalid ones.
module mem_arbiter #(
   parameter logic [24:0] BASE_ADDRESS = 25'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nxt;
   logic        last_grant;
   logic        winner;
   logic        we_l;
   logic        err_l;
   logic [31:0] addr_l;
   logic [31:0] wdata_l;

   logic        any_req;
   logic        gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_ok;

   // On a tie the port that did not win last time is granted.
   assign any_req   = req0 | req1;
   assign gnt       = (req0 & req1) ? ~last_grant : req1;
   assign sel_we    = gnt ? we1 : we0;
   assign sel_addr  = gnt ? addr1 : addr0;
   assign sel_wdata = gnt ? wdata1 : wdata0;
   assign sel_ok    = (sel_addr[31:7] == BASE_ADDRESS) && (sel_addr[1:0] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Strobes and acks decode from state so reset removes them without a clock edge.
   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = sel_ok ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            mem_read  = ~we_l;
            mem_write = we_l;
            state_nxt = RESP;
         end
         RESP: begin
            ack0      = ~winner;
            ack1      = winner;
            err0      = ~winner & err_l;
            err1      = winner & err_l;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         winner     <= 1'b0;
         we_l       <= 1'b0;
         err_l      <= 1'b0;
         addr_l     <= '0;
         wdata_l    <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            winner     <= gnt;
            last_grant <= gnt;
            we_l       <= sel_we;
            addr_l     <= sel_addr;
            wdata_l    <= sel_wdata;
            err_l      <= ~sel_ok;
            // Memory bus only moves for requests that will actually reach ACCESS.
            if (sel_ok) begin
               mem_addr  <= sel_addr;
               mem_wdata <= sel_wdata;
            end
         end
         if (state == ACCESS && !we_l) begin
            if (winner) begin
               rdata1 <= mem_rdata;
            end else begin
               rdata0 <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory on the memory port.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy;

   logic [31:0] mem [32];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[6:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;

   mem_arbiter #(.BASE_ADDRESS(25'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int port, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      if (port == 0) begin
         req0 = r; we0 = w; addr0 = a; wdata0 = d;
      end else begin
         req1 = r; we1 = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_acks", {ack0, ack1, err0, err1}, 0);
      check("rst_strobes", {mem_read, mem_write}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Starts #1 after a rising edge; returns #1 after the edge that closes RESP.
   task automatic run_txn(input int port, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic corrupt);
      drive(port, 1'b1, w, a, d);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_strobes", {mem_read, mem_write}, 0);
      @(posedge clk);
      if (!exp_err) begin
         if (corrupt) begin
            #1 drive(port, 1'b1, w, 32'h0, 32'hFFFF_FFFF);
         end
         @(negedge clk);
         check("acc_read", mem_read, !w);
         check("acc_write", mem_write, w);
         check("acc_addr", mem_addr, a);
         if (w) check("acc_wdata", mem_wdata, d);
         check("acc_noack", {ack0, ack1}, 0);
         @(posedge clk);
      end
      @(negedge clk);
      check("resp_ack", port ? ack1 : ack0, 1);
      check("resp_other_ack", port ? ack0 : ack1, 0);
      check("resp_err", port ? err1 : err0, exp_err);
      check("resp_strobes", {mem_read, mem_write}, 0);
      check("resp_rdata", port ? rdata1 : rdata0, exp_rdata);
      @(posedge clk);
      #1 drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
      check("after_resp_idle", busy, 0);
   endtask

   int ack_cyc[$];
   int ack_port[$];
   int both_hi;

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_strobes", {mem_read, mem_write}, 0);
      check("reset_acks", {ack0, ack1, err0, err1}, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_mem_wdata", mem_wdata, 0);
      check("reset_rdata0", rdata0, 0);
      check("reset_rdata1", rdata1, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      run_txn(0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, 1'b0);
      run_txn(0, 1'b0, 32'h0000_0082, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      run_txn(0, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      check("err_no_mem_addr_move", mem_addr, 32'h0000_0000);

      run_txn(1, 1'b1, 32'h0000_007C, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      check("stable_mem7c", mem[31], 32'h1234_5678);
      check("stable_mem00", mem[0], 32'hCAFE_F00D);
      run_txn(1, 1'b0, 32'h0000_007C, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
      run_txn(1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 1'b0, 32'h1234_5678, 1'b0);

      // Abandon a write mid-ACCESS with an asynchronous reset.
      drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111);
      @(posedge clk);
      @(negedge clk);
      check("midrst_write_before", mem_write, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_write_dropped", mem_write, 0);
      check("midrst_busy", busy, 0);
      check("midrst_mem_addr", mem_addr, 0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_ack", {ack0, ack1}, 0);
      end
      check("midrst_mem_kept", mem[8], 32'hAAAA_5555);
      @(posedge clk);
      #1;
      run_txn(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hAAAA_5555, 1'b0);

      // Both ports held high after reset: expect 0,1,0,1 every three cycles.
      do_reset();
      @(posedge clk);
      #1;
      drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      both_hi = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (ack0 && ack1) both_hi++;
         if (ack0) begin ack_cyc.push_back(k); ack_port.push_back(0); end
         if (ack1) begin ack_cyc.push_back(k); ack_port.push_back(1); end
      end
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("rr_both_high", both_hi, 0);
      check("rr_ack_count", ack_cyc.size(), 4);
      for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
         check($sformatf("rr_port_%0d", i), ack_port[i], i % 2);
         check($sformatf("rr_cycle_%0d", i), ack_cyc[i], 2 + 3 * i);
      end
      check("rr_rdata0", rdata0, 32'hDEAD_BEEF);
      check("rr_rdata1", rdata1, 32'hAAAA_5555);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
